// File: rtl/fir_coef_sequencer.sv
// -----------------------------------------------------------------------------
// fir_coef_sequencer
//
// Controller in front of a 7-tap symmetric FIR filter. It keeps two banks of
// four half-coefficients (a, b, c, d). The filter mirrors each bank to
// [a b c d c b a]. On a reload request the selected bank is streamed into the
// filter's coefficient port. FLUSH_LEN zero samples then clear the delay line.
// After that a valid/ready sample stream is gated into the filter, and each
// filter output is tagged with a valid flag.
//
// Parameters
//   FIR_LAT    : cycles from fir_x_in being driven to the matching fir_y_in
//   FLUSH_LEN  : zero samples driven after a coefficient load (>= 1)
//
// Ports
//   clk, rst                 : clock; synchronous active-low reset
//   cfg_we/bank/addr/data    : host coefficient write
//   cfg_err                  : one-cycle pulse after a rejected write
//   reload_req, reload_bank  : request to load a bank into the filter
//   busy                     : high while loading or flushing
//   loaded                   : a load has completed since reset
//   active_bank              : bank currently in the filter
//   s_valid, s_data, s_ready : input sample handshake
//   fir_x_in, fir_coef_val,
//   fir_writeen, fir_tlast   : registered filter drive
//   fir_y_in                 : filter output
//   y_valid, y_data          : tagged filter output
// -----------------------------------------------------------------------------
module fir_coef_sequencer #(
    parameter int FIR_LAT   = 1,
    parameter int FLUSH_LEN = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_we,
    input  logic        cfg_bank,
    input  logic [1:0]  cfg_addr,
    input  logic [7:0]  cfg_data,
    output logic        cfg_err,
    input  logic        reload_req,
    input  logic        reload_bank,
    output logic        busy,
    output logic        loaded,
    output logic        active_bank,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic [7:0]  fir_x_in,
    output logic [7:0]  fir_coef_val,
    output logic        fir_writeen,
    output logic        fir_tlast,
    input  logic [17:0] fir_y_in,
    output logic        y_valid,
    output logic [17:0] y_data
);

    localparam int FCW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
    localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    state_t                 state_r, state_s;
    logic [1:0]             idx_r, idx_s;
    logic [FCW-1:0]         flush_cnt_r, flush_cnt_s;
    logic                   load_bank_r, load_bank_s;
    logic [1:0][3:0][7:0]   bank_r;

    logic                   busy_s;
    logic                   s_ready_s;
    logic                   accept_s;
    logic                   wr_ok_s;
    logic [7:0]             coef_s;

    logic                   cfg_err_r;
    logic                   loaded_r;
    logic                   active_bank_r;
    logic [7:0]             x_r;
    logic [7:0]             coef_r;
    logic                   writeen_r;
    logic                   tlast_r;
    // tag_r[0] is aligned with fir_x_in; tag_r[FIR_LAT] with fir_y_in.
    logic [FIR_LAT:0]       tag_r;
    logic [17:0]            y_hold_r;

    // A write is refused only when it targets the bank that is being loaded or flushed.
    assign busy_s    = (state_r == ST_LOAD) || (state_r == ST_FLUSH);
    assign s_ready_s = (state_r == ST_RUN) && !reload_req;
    assign accept_s  = s_valid && s_ready_s;
    assign wr_ok_s   = cfg_we && !(busy_s && (cfg_bank == load_bank_r));

    // Next-state, load index and flush counter sequencing
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        flush_cnt_s = flush_cnt_r;
        load_bank_s = load_bank_r;
        case (state_r)
            ST_IDLE, ST_RUN: begin
                if (reload_req) begin
                    state_s     = ST_LOAD;
                    idx_s       = 2'd0;
                    load_bank_s = reload_bank;
                end else begin
                    state_s     = state_r;
                end
            end
            ST_LOAD: begin
                if (idx_r == 2'd3) begin
                    state_s     = ST_FLUSH;
                    flush_cnt_s = {FCW{1'b0}};
                end else begin
                    idx_s       = idx_r + 2'd1;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_r == FLUSH_LAST) begin
                    state_s     = ST_RUN;
                end else begin
                    flush_cnt_s = flush_cnt_r + FCW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Coefficient for the next LOAD cycle; a same-cycle write to that entry
    // is forwarded so the freshly written value is loaded.
    always_comb begin
        coef_s = bank_r[load_bank_s][idx_s];
        if (wr_ok_s && (cfg_bank == load_bank_s) && (cfg_addr == idx_s)) begin
            coef_s = cfg_data;
        end else begin
            coef_s = bank_r[load_bank_s][idx_s];
        end
    end

    // FSM state, load bookkeeping and coefficient banks
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            idx_r         <= 2'd0;
            flush_cnt_r   <= {FCW{1'b0}};
            load_bank_r   <= 1'b0;
            bank_r        <= {64{1'b0}};
            cfg_err_r     <= 1'b0;
            loaded_r      <= 1'b0;
            active_bank_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            flush_cnt_r <= flush_cnt_s;
            load_bank_r <= load_bank_s;
            cfg_err_r   <= cfg_we && !wr_ok_s;
            if (wr_ok_s) begin
                bank_r[cfg_bank][cfg_addr] <= cfg_data;
            end
            if ((state_r == ST_LOAD) && (idx_r == 2'd3)) begin
                loaded_r      <= 1'b1;
                active_bank_r <= load_bank_r;
            end
        end
    end

    // Registered filter drive: decoded from the next state so that the
    // outputs line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (!rst) begin
            x_r       <= 8'd0;
            coef_r    <= 8'd0;
            writeen_r <= 1'b0;
            tlast_r   <= 1'b0;
        end else begin
            x_r <= accept_s ? s_data : 8'd0;
            if (state_s == ST_LOAD) begin
                coef_r    <= coef_s;
                writeen_r <= 1'b1;
                tlast_r   <= (idx_s == 2'd3);
            end else begin
                coef_r    <= 8'd0;
                writeen_r <= 1'b0;
                tlast_r   <= 1'b0;
            end
        end
    end

    // Valid-tag delay line and held output value
    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_r    <= {(FIR_LAT+1){1'b0}};
            y_hold_r <= 18'd0;
        end else begin
            tag_r <= {tag_r[FIR_LAT-1:0], accept_s};
            if (tag_r[FIR_LAT]) begin
                y_hold_r <= fir_y_in;
            end
        end
    end

    assign cfg_err      = cfg_err_r;
    assign busy         = busy_s;
    assign loaded       = loaded_r;
    assign active_bank  = active_bank_r;
    assign s_ready      = s_ready_s;
    assign fir_x_in     = x_r;
    assign fir_coef_val = coef_r;
    assign fir_writeen  = writeen_r;
    assign fir_tlast    = tlast_r;
    assign y_valid      = tag_r[FIR_LAT];
    // The filter output passes straight through while tagged and is held otherwise.
    assign y_data       = tag_r[FIR_LAT] ? fir_y_in : y_hold_r;

endmodule
